// File: rtl/interrupter_scheduler.sv
// rtl/interrupter_scheduler.sv - DRSSTC interrupter: validated double-buffered config to periodic gate-enable burst
module interrupter_scheduler #(
    parameter int W        = 8,
    parameter int TICK_DIV = 4,
    parameter int ON_MAX   = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cfg_on_time,
    input  logic [W-1:0] cfg_period,
    input  logic         cfg_valid,
    input  logic         enable,
    input  logic         fault,
    input  logic         fault_clr,
    output logic         gate_en,
    output logic [1:0]   state,
    output logic         cfg_reject,
    output logic         fault_latched
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ON    = 2'b01;
    localparam logic [1:0] S_OFF   = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  ON_MAX_W = W'(ON_MAX);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  on_p_q, on_p_d, per_p_q, per_p_d;
    logic [W-1:0]  on_a_q, on_a_d, per_a_q, per_a_d;
    logic          has_cfg_q, has_cfg_d;
    logic          cfg_reject_q, cfg_reject_d;

    logic          cfg_ok, cfg_take, tick, enter_on;
    logic [W-1:0]  cnt_nxt;

    always_comb begin
        cfg_ok   = (cfg_on_time != '0) && (cfg_on_time <= ON_MAX_W) && (cfg_period > cfg_on_time);
        cfg_take = cfg_valid && cfg_ok;
        tick     = (pre_q == PRE_LAST);
        cnt_nxt  = cnt_q + W'(1);

        state_d  = state_q;
        enter_on = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && has_cfg_q) begin
                    state_d  = S_ON;
                    enter_on = 1'b1;
                end
            end
            S_ON: begin
                // Dropping enable cuts the gate now but the period still runs out.
                if (!enable || (tick && cnt_nxt == on_a_q))
                    state_d = S_OFF;
            end
            S_OFF: begin
                if (tick && cnt_nxt == per_a_q) begin
                    if (enable) begin
                        state_d  = S_ON;
                        enter_on = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                if (fault_clr && !fault)
                    state_d = S_IDLE;
            end
        endcase
        if (fault) begin
            state_d  = S_FAULT;
            enter_on = 1'b0;
        end

        pre_d = '0;
        cnt_d = '0;
        if (!enter_on && (state_q == S_ON || state_q == S_OFF)) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            cnt_d = tick ? cnt_nxt : cnt_q;
        end

        // A strobe coinciding with a period start goes straight to the active set.
        on_a_d  = on_a_q;
        per_a_d = per_a_q;
        if (enter_on) begin
            on_a_d  = cfg_take ? cfg_on_time : on_p_q;
            per_a_d = cfg_take ? cfg_period  : per_p_q;
        end

        on_p_d       = cfg_take ? cfg_on_time : on_p_q;
        per_p_d      = cfg_take ? cfg_period  : per_p_q;
        has_cfg_d    = has_cfg_q | cfg_take;
        cfg_reject_d = cfg_valid && !cfg_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pre_q        <= '0;
            cnt_q        <= '0;
            on_p_q       <= '0;
            per_p_q      <= '0;
            on_a_q       <= '0;
            per_a_q      <= '0;
            has_cfg_q    <= 1'b0;
            cfg_reject_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            on_p_q       <= on_p_d;
            per_p_q      <= per_p_d;
            on_a_q       <= on_a_d;
            per_a_q      <= per_a_d;
            has_cfg_q    <= has_cfg_d;
            cfg_reject_q <= cfg_reject_d;
        end
    end

    assign state         = state_q;
    assign gate_en       = (state_q == S_ON);
    assign fault_latched = (state_q == S_FAULT);
    assign cfg_reject    = cfg_reject_q;
endmodule
